wash_sequencer: RTL and testbench
=================================

WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 SHALL provide parameter RINSES, default 2, number of rinse fill/agitate/drain passes after the soap pass (0..7).
REQ-002 SHALL provide parameter TMR_W, default 16, width of the internal phase timer.
REQ-003 SHALL provide parameter WASH_TICKS, default 1000, AGITATE duration in clk cycles (>=1).
REQ-004 SHALL provide parameter SPIN_TICKS, default 500, SPIN duration in clk cycles (>=1).
REQ-005 SHALL provide parameter WATER_LIMIT, default 4000, maximum cycles in FILL or DRAIN before fault (>=2).
REQ-006 SHALL provide ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- door_close  in  1  door-closed sensor.
- start  in  1  begin program.
- abort  in  1  cancel program, drain, return to idle.
- filled  in  1  water level reached.
- drained  in  1  drum empty.
- detergent_added  in  1  detergent dispensed.
- door_lock  out  1  lock solenoid.
- fill_valve_on  out  1  inlet valve.
- drain_valve_on  out  1  drain pump/valve.
- motor_on  out  1  drum motor.
- spin_hi  out  1  high-speed motor mode.
- soap_phase  out  1  soap pass active.
- done  out  1  one-cycle completion pulse.
- fault  out  1  fault latched.
- state  out  3  current state code.
- rinse_left  out  3  rinse passes remaining.

Function
REQ-007 SHALL implement states IDLE=0, FILL=1, DETERGENT=2, AGITATE=3, DRAIN=4, SPIN=5, FAULT=6; code 7 SHALL go to IDLE next cycle.
REQ-008 Outputs SHALL be registered Moore decodes of state, except done:
- IDLE: all 0.
- FILL: door_lock, fill_valve_on.
- DETERGENT: door_lock.
- AGITATE: door_lock, motor_on.
- DRAIN: door_lock, drain_valve_on.
- SPIN: door_lock, motor_on, spin_hi, drain_valve_on.
- FAULT: door_lock, fault.
REQ-009 Timer SHALL clear on every state change and increment by 1 each cycle otherwise, saturating at all-ones.
REQ-010 IDLE -> FILL when start=1 and door_close=1; on that edge rinse_left<=RINSES and soap_phase<=1, abort latch cleared.
REQ-011 FILL -> DETERGENT on filled=1 when soap_phase=1; FILL -> AGITATE on filled=1 when soap_phase=0.
REQ-012 DETERGENT -> AGITATE on detergent_added=1; no timeout in DETERGENT.
REQ-013 AGITATE -> DRAIN when timer==WASH_TICKS-1, so AGITATE lasts exactly WASH_TICKS cycles.
REQ-014 DRAIN on drained=1:
- abort latch set -> IDLE, no done.
- else rinse_left==0 -> SPIN.
- else -> FILL, with rinse_left decremented and soap_phase<=0.
REQ-015 SPIN -> IDLE when timer==SPIN_TICKS-1; done SHALL be 1 for exactly the first cycle in IDLE after SPIN.
REQ-016 FILL/DRAIN -> FAULT when timer==WATER_LIMIT-1 and filled/drained is 0; sensor=1 in that same cycle wins.
REQ-017 Any state FILL..SPIN with door_close=0 SHALL go to FAULT next cycle.
REQ-018 abort=1 in FILL, DETERGENT, AGITATE or SPIN SHALL set the abort latch and go to DRAIN.
REQ-019 abort=1 in DRAIN SHALL set the latch and remain in DRAIN.
REQ-020 abort SHALL be ignored in IDLE and FAULT.
REQ-021 Priority within a cycle SHALL be door fault > water-limit fault > abort > normal transition.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 FAULT SHALL be exited only by reset.

Reset
REQ-024 reset=1 SHALL asynchronously force state=IDLE, timer=0, rinse_left=0, soap_phase=0, abort latch=0 and all outputs 0, including mid-program.
REQ-025 After reset deasserts, the first transition SHALL be evaluated on the following clk rising edge.

Verification
Scenarios use RINSES=1, WASH_TICKS=4, SPIN_TICKS=3, WATER_LIMIT=8.
REQ-026 Full program: start+door_close, filled/detergent_added/drained each pulsed 2 cycles after entry -> state sequence 1,2,3,4,1,3,4,5,0; AGITATE 4 cycles each, SPIN 3 cycles, single done pulse, rinse_left 1->0.
REQ-027 Fill timeout: start, filled held 0 -> FAULT after exactly 8 FILL cycles, fault=1, door_lock=1, valves 0; start ignored; reset -> IDLE, all outputs 0.
REQ-028 Boundary: filled=1 in 8th FILL cycle -> DETERGENT, no fault; door_close=0 during AGITATE -> FAULT next cycle, even with abort=1 same cycle.
REQ-029 Abort in AGITATE -> DRAIN; drained=1 -> IDLE with done=0, door_lock=0; abort pulse in IDLE -> no state change.
REQ-030 Reset asserted mid-SPIN (async, between edges) -> outputs 0 immediately; next start runs a complete program with rinse_left reloaded to 1.

Source files
------------

// File: rtl/wash_sequencer.sv
// wash_sequencer: washing-machine program controller.
// Runs one soap pass (fill, detergent, agitate, drain) followed by RINSES rinse passes
// (fill, agitate, drain) and a final spin. Door-open and water-timeout conditions latch FAULT,
// which is left only through reset. abort drains the drum and returns to IDLE without done.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   door_close          door-closed sensor
//   start               begin program (honoured in IDLE only)
//   abort               cancel program: drain, then IDLE
//   filled, drained     water level sensors
//   detergent_added     detergent dispenser feedback
//   door_lock .. spin_hi  registered actuator decodes of the state
//   soap_phase          soap pass in progress
//   done                one-cycle pulse on SPIN -> IDLE
//   fault               FAULT state indicator
//   state               current state code
//   rinse_left          rinse passes still to run
module wash_sequencer #(
  parameter int unsigned RINSES      = 2,
  parameter int unsigned TMR_W       = 16,
  parameter int unsigned WASH_TICKS  = 1000,
  parameter int unsigned SPIN_TICKS  = 500,
  parameter int unsigned WATER_LIMIT = 4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       door_close,
  input  logic       start,
  input  logic       abort,
  input  logic       filled,
  input  logic       drained,
  input  logic       detergent_added,
  output logic       door_lock,
  output logic       fill_valve_on,
  output logic       drain_valve_on,
  output logic       motor_on,
  output logic       spin_hi,
  output logic       soap_phase,
  output logic       done,
  output logic       fault,
  output logic [2:0] state,
  output logic [2:0] rinse_left
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFill      = 3'd1,
    StDetergent = 3'd2,
    StAgitate   = 3'd3,
    StDrain     = 3'd4,
    StSpin      = 3'd5,
    StFault     = 3'd6,
    StBad       = 3'd7
  } state_e;

  localparam logic [TMR_W-1:0] WashLast  = TMR_W'(WASH_TICKS - 1);
  localparam logic [TMR_W-1:0] SpinLast  = TMR_W'(SPIN_TICKS - 1);
  localparam logic [TMR_W-1:0] WaterLast = TMR_W'(WATER_LIMIT - 1);
  localparam logic [2:0]       RinseLoad = 3'(RINSES);

  state_e           r_state, w_state_d;
  logic [TMR_W-1:0] r_tmr;
  logic [2:0]       r_rinse, w_rinse_d;
  logic             r_soap, w_soap_d;
  logic             r_abort, w_abort_d;
  logic             w_active, w_door_fault, w_water_fault;

  assign w_active      = (r_state inside {StFill, StDetergent, StAgitate, StDrain, StSpin});
  assign w_door_fault  = w_active && !door_close;
  // A sensor asserted in the last allowed cycle rescues the phase.
  assign w_water_fault = (r_tmr == WaterLast) &&
                         (((r_state == StFill) && !filled) || ((r_state == StDrain) && !drained));

  always_comb begin
    w_state_d = r_state;
    w_rinse_d = r_rinse;
    w_soap_d  = r_soap;
    w_abort_d = r_abort;
    case (r_state)
      StIdle: begin
        if (start && door_close) begin
          w_state_d = StFill;
          w_rinse_d = RinseLoad;
          w_soap_d  = 1'b1;
          w_abort_d = 1'b0;
        end
      end
      StFault: w_state_d = StFault;
      StBad:   w_state_d = StIdle;
      default: begin
        if (w_door_fault || w_water_fault) begin
          w_state_d = StFault;
        end else if (abort) begin
          w_abort_d = 1'b1;
          w_state_d = StDrain;
        end else begin
          case (r_state)
            StFill:      if (filled) w_state_d = r_soap ? StDetergent : StAgitate;
            StDetergent: if (detergent_added) w_state_d = StAgitate;
            StAgitate:   if (r_tmr == WashLast) w_state_d = StDrain;
            StDrain: begin
              if (drained) begin
                if (r_abort) begin
                  w_state_d = StIdle;
                end else if (r_rinse == 3'd0) begin
                  w_state_d = StSpin;
                end else begin
                  w_state_d = StFill;
                  w_rinse_d = r_rinse - 3'd1;
                  w_soap_d  = 1'b0;
                end
              end
            end
            StSpin:      if (r_tmr == SpinLast) w_state_d = StIdle;
            default:     w_state_d = StIdle;
          endcase
        end
      end
    endcase
    // Program bookkeeping reads zero whenever the machine is idle.
    if (w_state_d == StIdle) begin
      w_rinse_d = 3'd0;
      w_soap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_tmr   <= '0;
      r_rinse <= 3'd0;
      r_soap  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_rinse <= w_rinse_d;
      r_soap  <= w_soap_d;
      r_abort <= w_abort_d;
      if (w_state_d != r_state) begin
        r_tmr <= '0;
      end else if (r_tmr != '1) begin
        r_tmr <= r_tmr + 1'b1;
      end
    end
  end

  // Actuators are decoded from the next state so they change together with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      door_lock      <= 1'b0;
      fill_valve_on  <= 1'b0;
      drain_valve_on <= 1'b0;
      motor_on       <= 1'b0;
      spin_hi        <= 1'b0;
      fault          <= 1'b0;
      done           <= 1'b0;
    end else begin
      door_lock      <= (w_state_d inside {StFill, StDetergent, StAgitate, StDrain, StSpin,
                                           StFault});
      fill_valve_on  <= (w_state_d == StFill);
      drain_valve_on <= (w_state_d == StDrain) || (w_state_d == StSpin);
      motor_on       <= (w_state_d == StAgitate) || (w_state_d == StSpin);
      spin_hi        <= (w_state_d == StSpin);
      fault          <= (w_state_d == StFault);
      done           <= (r_state == StSpin) && (w_state_d == StIdle);
    end
  end

  assign state      = r_state;
  assign rinse_left = r_rinse;
  assign soap_phase = r_soap;

endmodule

// File: tb/tb_wash_sequencer.sv
module tb_wash_sequencer;
  localparam int Rin = 1;
  localparam int Wt  = 4;
  localparam int St  = 3;
  localparam int Wl  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic door_close = 1'b0, start = 1'b0, abort = 1'b0;
  logic filled = 1'b0, drained = 1'b0, detergent_added = 1'b0;
  logic door_lock, fill_valve_on, drain_valve_on, motor_on, spin_hi, soap_phase, done, fault;
  logic [2:0] state, rinse_left;

  wash_sequencer #(
    .RINSES(Rin), .TMR_W(16), .WASH_TICKS(Wt), .SPIN_TICKS(St), .WATER_LIMIT(Wl)
  ) dut (
    .clk(clk), .reset(reset), .door_close(door_close), .start(start), .abort(abort),
    .filled(filled), .drained(drained), .detergent_added(detergent_added),
    .door_lock(door_lock), .fill_valve_on(fill_valve_on), .drain_valve_on(drain_valve_on),
    .motor_on(motor_on), .spin_hi(spin_hi), .soap_phase(soap_phase), .done(done),
    .fault(fault), .state(state), .rinse_left(rinse_left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: program position as plain integers.
  int m_st, m_tmr, m_rin, m_soap, m_ab, m_done;

  typedef struct {
    logic [5:0] in;   // {door, start, abort, filled, drained, detergent}
    logic [6:0] exp;  // {state, done, rinse_left}
  } vec_t;
  vec_t prog[$];

  function automatic logic [13:0] dut_vec();
    return {state, rinse_left, door_lock, fill_valve_on, drain_valve_on, motor_on, spin_hi,
            soap_phase, done, fault};
  endfunction

  function automatic logic [13:0] model_vec();
    logic [13:0] v;
    v[13:11] = 3'(m_st);
    v[10:8]  = 3'(m_rin);
    v[7]     = (m_st >= 1 && m_st <= 6);
    v[6]     = (m_st == 1);
    v[5]     = (m_st == 4 || m_st == 5);
    v[4]     = (m_st == 3 || m_st == 5);
    v[3]     = (m_st == 5);
    v[2]     = (m_soap != 0);
    v[1]     = (m_done != 0);
    v[0]     = (m_st == 6);
    return v;
  endfunction

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_st(input string name, input int exp);
    checks++;
    if (state !== 3'(exp)) begin
      errors++;
      $display("FAIL %s state got=%0d expected=%0d at %0t", name, state, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_tmr = 0; m_rin = 0; m_soap = 0; m_ab = 0; m_done = 0;
  endtask

  task automatic model_step();
    int ns;
    ns = m_st;
    if (m_st == 0) begin
      if (start && door_close) begin
        ns = 1; m_rin = Rin; m_soap = 1; m_ab = 0;
      end
    end else if (m_st == 6) begin
      ns = 6;
    end else if (!door_close) begin
      ns = 6;
    end else if (m_tmr == Wl - 1 && ((m_st == 1 && !filled) || (m_st == 4 && !drained))) begin
      ns = 6;
    end else if (abort) begin
      m_ab = 1; ns = 4;
    end else begin
      case (m_st)
        1: if (filled) ns = (m_soap != 0) ? 2 : 3;
        2: if (detergent_added) ns = 3;
        3: if (m_tmr == Wt - 1) ns = 4;
        4: if (drained) begin
             if (m_ab != 0) ns = 0;
             else if (m_rin == 0) ns = 5;
             else begin ns = 1; m_rin--; m_soap = 0; end
           end
        5: if (m_tmr == St - 1) ns = 0;
        default: ns = 0;
      endcase
    end
    m_done = (m_st == 5 && ns == 0) ? 1 : 0;
    if (ns == 0) begin m_rin = 0; m_soap = 0; end
    if (ns != m_st) m_tmr = 0;
    else if (m_tmr < 65535) m_tmr++;
    m_st = ns;
  endtask

  // Apply inputs, clock once, then compare every output against the model.
  task automatic step(input logic [5:0] in);
    {door_close, start, abort, filled, drained, detergent_added} = in;
    @(posedge clk);
    model_step();
    #1;
    check("cycle", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_outputs", dut_vec(), 14'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic add(input logic [5:0] in, input int st, input logic dn, input int rl);
    vec_t v;
    v.in  = in;
    v.exp = {3'(st), dn, 3'(rl)};
    prog.push_back(v);
  endtask

  task automatic run_prog(input int rows);
    for (int i = 0; i < rows; i++) begin
      step(prog[i].in);
      checks++;
      if ({state, done, rinse_left} !== prog[i].exp) begin
        errors++;
        $display("FAIL prog_row%0d got=%b expected=%b", i, {state, done, rinse_left},
                 prog[i].exp);
      end
    end
  endtask

  initial begin
    // Full program with RINSES=1: states 1,2,3,4,1,3,4,5,0.
    add(6'b110000, 1, 0, 1); add(6'b100000, 1, 0, 1); add(6'b100100, 2, 0, 1);
    add(6'b100000, 2, 0, 1); add(6'b100001, 3, 0, 1); add(6'b100000, 3, 0, 1);
    add(6'b100000, 3, 0, 1); add(6'b100000, 3, 0, 1); add(6'b100000, 4, 0, 1);
    add(6'b100000, 4, 0, 1); add(6'b100010, 1, 0, 0); add(6'b100000, 1, 0, 0);
    add(6'b100100, 3, 0, 0); add(6'b100000, 3, 0, 0); add(6'b100000, 3, 0, 0);
    add(6'b100000, 3, 0, 0); add(6'b100000, 4, 0, 0); add(6'b100000, 4, 0, 0);
    add(6'b100010, 5, 0, 0); add(6'b100000, 5, 0, 0); add(6'b100000, 5, 0, 0);
    add(6'b100000, 0, 1, 0); add(6'b100000, 0, 0, 0);

    model_reset();
    do_reset();
    run_prog(prog.size());

    // Fill timeout: exactly 8 FILL cycles, then FAULT; start ignored; reset clears.
    do_reset();
    step(6'b110000);
    repeat (7) step(6'b100000);
    check_st("fill_8th_cycle", 1);
    step(6'b100000);
    check_st("fill_timeout", 6);
    check("fault_outputs", {door_lock, fill_valve_on, drain_valve_on, fault}, 14'b1001);
    step(6'b110000);
    step(6'b110000);
    check_st("fault_ignores_start", 6);
    do_reset();
    check_st("fault_reset", 0);

    // Boundary: filled in 8th FILL cycle wins; door open beats abort.
    step(6'b110000);
    repeat (7) step(6'b100000);
    step(6'b100100);
    check_st("fill_last_cycle", 2);
    step(6'b100001);
    check_st("to_agitate", 3);
    step(6'b001000);
    check_st("door_beats_abort", 6);

    // Abort in AGITATE drains to IDLE with no done; abort in IDLE does nothing.
    do_reset();
    step(6'b110000);
    step(6'b100100);
    step(6'b100001);
    check_st("abort_pre", 3);
    step(6'b101000);
    check_st("abort_to_drain", 4);
    step(6'b100010);
    check_st("abort_drained", 0);
    check("abort_no_done", {done, door_lock}, 14'b00);
    step(6'b101000);
    check_st("abort_idle", 0);

    // Asynchronous reset mid-SPIN, then a complete program again.
    do_reset();
    run_prog(20);
    check_st("mid_spin", 5);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_reset", dut_vec(), 14'h0);
    @(negedge clk);
    reset = 1'b0;
    run_prog(prog.size());

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (m_st == 6 || $urandom_range(299) == 0) do_reset();
      step({($urandom_range(59) != 0), ($urandom_range(3) == 0), ($urandom_range(49) == 0),
            ($urandom_range(2) == 0), ($urandom_range(2) == 0), ($urandom_range(2) == 0)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
